// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: credit-limited req/gnt/rvalid fetch into a small queue,
// with redirect flushing the queue and discarding responses still owed by the old stream.
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   inst_q [DEPTH];

    logic [CW:0]   credit_used;
    logic          grant;
    logic          resp;
    logic          keep;
    logic          pop;
    logic [CW-1:0] inflight_after;
    logic [31:0]   redirect_pc;

    // Queue entries plus outstanding requests never exceed DEPTH, so a response always has a slot.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign mem_req_o      = rst_n & ~redirect_i & (credit_used < (CW+1)'(DEPTH));
    assign mem_addr_o     = fetch_pc;

    assign grant          = mem_req_o & mem_gnt_i;
    assign resp           = mem_rvalid_i & (inflight != '0);
    assign keep           = resp & (drop_cnt == '0) & ~redirect_i;
    assign inflight_after = inflight + CW'(grant) - CW'(resp);
    assign redirect_pc    = {redirect_pc_i[31:2], 2'b00};

    assign inst_valid_o   = (count != '0) & ~redirect_i;
    assign pop            = inst_valid_o & inst_ready_i;
    assign inst_o         = inst_valid_o ? inst_q[rd_ptr] : NOP_INST;
    assign inst_addr_o    = inst_valid_o ? addr_q[rd_ptr] : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_after;
            if (redirect_i) begin
                // Everything still outstanding belongs to the abandoned stream.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= inflight_after;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (keep) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({keep, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && keep) begin
            addr_q[wr_ptr] <= resp_pc;
            inst_q[wr_ptr] <= mem_rdata_i;
        end
    end

endmodule
